// File: rtl/fpga_gpio_pkg.sv
// Shared constants for the FPGA-side GPIO peripheral.
// Register word offsets on the Avalon-MM slave and the ID word fields.
// No logic here; imported by the top and the debounce channel.
package fpga_gpio_pkg;
   localparam logic [2:0] REG_BTN_STATE = 3'd0;
   localparam logic [2:0] REG_EDGE_CAP  = 3'd1;
   localparam logic [2:0] REG_IRQ_MASK  = 3'd2;
   localparam logic [2:0] REG_LED_OUT   = 3'd3;
   localparam logic [2:0] REG_LED_MODE  = 3'd4;
   localparam logic [2:0] REG_ID        = 3'd5;

   localparam logic [7:0] ID_MAGIC   = 8'h47;
   localparam logic [7:0] ID_VERSION = 8'h01;
endpackage

// File: rtl/gpio_debounce.sv
// One button channel: 2-FF synchroniser plus stability counter, active-low in, 1 = pressed out.
// Latency: input stable from edge k is accepted at edge k+1+DEBOUNCE_CYCLES.
// No backpressure; press_o is a single-cycle pulse aligned with the state update.
module gpio_debounce
   import fpga_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_n_i,
   output logic state_o,
   output logic press_o
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q, sync2_q;
   logic             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cand;

   // Synchroniser resets to released so a held button is not seen as a press during reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
      end
   end

   assign cand = ~sync2_q;

   // Count consecutive disagreeing cycles; the count reaching DEBOUNCE_CYCLES-1 accepts the change
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (cand != state_q) begin
         if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES - 1) begin
            state_d = cand;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Debounced state and counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;
   assign press_o = state_d & ~state_q;
endmodule

// File: rtl/fpga_gpio_ctrl.sv
// Avalon-MM GPIO peripheral: debounced buttons with press-edge irq, static/blink LEDs.
// Latency: readdata one cycle after avs_read; writes take effect on the write edge; irq one edge after EDGE_CAP.
// No waitrequest: every access completes in one cycle, the slave never stalls the bridge.
module fpga_gpio_ctrl
   import fpga_gpio_pkg::*;
#(
   parameter int N_BTN           = 3,
   parameter int N_LED           = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_DIV       = 25000000
) (
   input  logic             clock_100m,
   input  logic             reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   input  logic [N_BTN-1:0] fpga_button,
   output logic [N_LED-1:0] fpga_led
);
   localparam int BL_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [N_BTN-1:0] btn_state_w, btn_press_w;
   logic [N_BTN-1:0] cap_q, cap_d;
   logic [N_BTN-1:0] mask_q;
   logic [N_LED-1:0] led_out_q, led_mode_q;
   logic             irq_q;
   logic [31:0]      rdata_q, rdata_d;
   logic [BL_W-1:0]  blink_cnt_q;
   logic             phase_q;
   logic             unused_wdata;

   // Only the low channel bits of writedata are meaningful
   assign unused_wdata = ^avs_writedata;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk_i   (clock_100m),
         .rst_i   (reset),
         .btn_n_i (fpga_button[g]),
         .state_o (btn_state_w[g]),
         .press_o (btn_press_w[g])
      );
   end

   // W1C first, then OR in new presses so a press landing with a clear is never lost
   always_comb begin
      cap_d = cap_q;
      if (avs_write && avs_address == REG_EDGE_CAP) begin
         cap_d = cap_q & ~avs_writedata[N_BTN-1:0];
      end
      cap_d = cap_d | btn_press_w;
   end

   // Read mux samples pre-write state; unused bits and offsets 6/7 read 0
   always_comb begin
      rdata_d = '0;
      case (avs_address)
         REG_BTN_STATE: rdata_d[N_BTN-1:0] = btn_state_w;
         REG_EDGE_CAP:  rdata_d[N_BTN-1:0] = cap_q;
         REG_IRQ_MASK:  rdata_d[N_BTN-1:0] = mask_q;
         REG_LED_OUT:   rdata_d[N_LED-1:0] = led_out_q;
         REG_LED_MODE:  rdata_d[N_LED-1:0] = led_mode_q;
         REG_ID:        rdata_d = {ID_MAGIC, 8'(N_BTN), 8'(N_LED), ID_VERSION};
         default:       rdata_d = '0;
      endcase
   end

   // Register file, edge capture, registered irq and read data
   always_ff @(posedge clock_100m or posedge reset) begin
      if (reset) begin
         cap_q      <= '0;
         mask_q     <= '0;
         led_out_q  <= '0;
         led_mode_q <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         cap_q <= cap_d;
         irq_q <= |(cap_q & mask_q);
         if (avs_read) begin
            rdata_q <= rdata_d;
         end
         if (avs_write) begin
            case (avs_address)
               REG_IRQ_MASK: mask_q     <= avs_writedata[N_BTN-1:0];
               REG_LED_OUT:  led_out_q  <= avs_writedata[N_LED-1:0];
               REG_LED_MODE: led_mode_q <= avs_writedata[N_LED-1:0];
               default:      ;
            endcase
         end
      end
   end

   // Free-running blink divider: phase flips every BLINK_DIV cycles, first flip BLINK_DIV after reset
   always_ff @(posedge clock_100m or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (int'(blink_cnt_q) >= BLINK_DIV - 1) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BL_W'(1);
      end
   end

   assign fpga_led     = led_out_q & (~led_mode_q | {N_LED{phase_q}});
   assign irq          = irq_q;
   assign avs_readdata = rdata_q;
endmodule

// File: doc/fpga_gpio_ctrl.md
# fpga_gpio_ctrl

Parametrised Avalon-MM GPIO peripheral for the FPGA-side user buttons and LEDs on the Helio board. It sits in the Qsys system next to the HPS and the Hamming accelerator, on the lightweight HPS-to-FPGA bridge. It debounces active-low buttons, captures press edges with a maskable interrupt, and drives LEDs in static or blink mode. It generalises the fixed 3-button/3-LED pins into N channels with software control.

## Interface
- N_BTN, 3, number of button inputs (1..8)
- N_LED, 3, number of LED outputs (1..8)
- DEBOUNCE_CYCLES, 1000000, stable cycles needed to accept a button change (10 ms at 100 MHz)
- BLINK_DIV, 25000000, cycles per blink phase toggle
- clock_100m  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid one cycle after avs_read
- irq  out  1  level interrupt, active-high
- fpga_button  in  N_BTN  raw buttons, active-low, asynchronous to clock_100m
- fpga_led  out  N_LED  LED drive, active-high

## Operation
- Register map (word offsets):
  - 0 BTN_STATE, RO: debounced state, 1 = pressed.
  - 1 EDGE_CAP, RW1C: press-edge flags.
  - 2 IRQ_MASK, RW.
  - 3 LED_OUT, RW.
  - 4 LED_MODE, RW: per LED, 0 = static, 1 = blink.
  - 5 ID, RO: {8'h47, N_BTN, N_LED, 8'h01}.
  - 6, 7: read 0, writes ignored.
  - Unused upper bits read 0.
- Per button:
  - 2-FF synchroniser; sync FFs reset to 1 (released).
  - Candidate = inverted synchronised level.
  - If candidate != state, the counter increments. Counter reaching DEBOUNCE_CYCLES-1 loads the state and clears the counter.
  - If candidate == state, the counter clears.
- Edge capture:
  - A 0->1 transition of debounced state sets the EDGE_CAP bit.
  - Release does not set EDGE_CAP.
  - A set and a W1C to the same bit in the same cycle: set wins.
- irq = registered |(EDGE_CAP & IRQ_MASK).
- Blink:
  - A free-running counter toggles `phase` every BLINK_DIV cycles. `phase` resets to 0.
  - fpga_led = LED_OUT & (~LED_MODE | {N_LED{phase}}).
- Reset values: every register, counter and phase is 0. Outputs after reset: fpga_led=0, irq=0, avs_readdata=0.
- Reset mid-debounce: the counter clears and no edge is recorded.

## Timing
- Read: avs_readdata is registered and valid on the edge after avs_read. It holds its value until the next read.
- Write: the register updates on the avs_write edge and is visible on fpga_led the following cycle.
- No waitrequest; every access completes in one cycle.
- Button latency: if fpga_button is stable from edge k, the synchroniser output changes at k+2. BTN_STATE and EDGE_CAP update at edge k+1+DEBOUNCE_CYCLES. irq asserts one edge later.
- A read of EDGE_CAP in the same cycle as a set returns the pre-set value.
- Blink period: 2*BLINK_DIV cycles. The first toggle is BLINK_DIV cycles after reset release.

## Structure
- Package fpga_gpio_pkg holds:
  - register offset constants (REG_BTN_STATE ... REG_ID)
  - ID magic 8'h47 and version 8'h01
- Sub-module gpio_debounce (one channel: synchroniser plus counter, DEBOUNCE_CYCLES parameter) is instantiated N_BTN times via generate.
- The top module holds the register file, edge/irq logic and blink divider.

## Test plan
All runs use DEBOUNCE_CYCLES=8 and BLINK_DIV=4.
- Reset and ID: assert reset mid-clock with defaults N_BTN=3, N_LED=3 -> fpga_led=0 and irq=0 immediately; reading offset 5 returns 0x47030301.
- Clean press: drive fpga_button[0]=0 at edge k, held 20 cycles, with IRQ_MASK=1 -> BTN_STATE=1 and EDGE_CAP=1 at edge k+9, irq=1 at k+10. Write 1 to EDGE_CAP -> irq=0 two cycles later.
- Glitch: fpga_button[1]=0 for 5 cycles then 1 -> BTN_STATE and EDGE_CAP stay 0; a release bounce shorter than 8 cycles does not clear BTN_STATE.
- W1C collision: a W1C of EDGE_CAP bit 2 in the same cycle that button 2's debounced press lands -> bit 2 reads 1.
- LEDs: write LED_OUT=3'b101 and LED_MODE=3'b100 -> fpga_led[0]=1 steady, fpga_led[1]=0, fpga_led[2] toggles every 4 cycles; LED_MODE=0 -> fpga_led[2]=1 steady.
- Reset mid-debounce: button held low for 5 cycles, then pulse reset -> no EDGE_CAP; a new full debounce period from reset release is needed before BTN_STATE=1.
